// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencing, hazard detection, forwarding and perf counters
module pipe_hazard_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_inst_i,
  input  logic              id_valid_i,
  input  logic              br_taken_i,
  input  logic              mem_stall_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [31:0]       ex_inst_o,
  output logic [31:0]       mem_inst_o,
  output logic [31:0]       wb_inst_o,
  output logic              ex_valid_o,
  output logic              mem_valid_o,
  output logic              wb_valid_o,
  output logic              reg_w_en_o,
  output logic              mem_we_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_OP    = 7'b0110011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_ST    = 7'b0100011;
  typedef logic [REG_AW-1:0] ra_t;
  function automatic logic wr_rd(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
  endfunction
  function automatic logic use_rs1(input logic [6:0] op);
    return op inside {OP_JALR, OP_BR, OP_LOAD, OP_ST, OP_IMM, OP_OP};
  endfunction
  function automatic logic use_rs2(input logic [6:0] op);
    return op inside {OP_BR, OP_ST, OP_OP};
  endfunction
  // A used source matches a valid, non-x0 destination of a producing stage
  function automatic logic dep(input logic v, input logic [6:0] op, input ra_t rd, input ra_t src, input logic used);
    return v && used && wr_rd(op) && (rd != '0) && (rd == src);
  endfunction
  logic [31:0]      ex_inst, mem_inst, wb_inst;
  logic             ex_valid, mem_valid, wb_valid;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       id_op, ex_op, mem_op, wb_op;
  ra_t              id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             dep_ex, dep_mem, hz, bubble;
  logic [1:0]       sel_a, sel_b;
  logic             unused_bits;
  assign id_op       = id_inst_i[6:0];
  assign id_rs1      = id_inst_i[15 +: REG_AW];
  assign id_rs2      = id_inst_i[20 +: REG_AW];
  assign ex_op       = ex_inst[6:0];
  assign ex_rs1      = ex_inst[15 +: REG_AW];
  assign ex_rs2      = ex_inst[20 +: REG_AW];
  assign ex_rd       = ex_inst[7 +: REG_AW];
  assign mem_op      = mem_inst[6:0];
  assign mem_rd      = mem_inst[7 +: REG_AW];
  assign wb_op       = wb_inst[6:0];
  assign wb_rd       = wb_inst[7 +: REG_AW];
  assign unused_bits = ^id_inst_i;
  // Hazard detection on ID, operand source selects for EX and the per-cycle control outputs
  always_comb begin
    dep_ex  = dep(ex_valid, ex_op, ex_rd, id_rs1, use_rs1(id_op)) || dep(ex_valid, ex_op, ex_rd, id_rs2, use_rs2(id_op));
    dep_mem = dep(mem_valid, mem_op, mem_rd, id_rs1, use_rs1(id_op)) || dep(mem_valid, mem_op, mem_rd, id_rs2, use_rs2(id_op));
    hz      = id_valid_i && (FWD_EN ? (dep_ex && ex_op == OP_LOAD) : (dep_ex || dep_mem));
    bubble  = br_taken_i || hz;
    sel_a   = (dep(mem_valid, mem_op, mem_rd, ex_rs1, use_rs1(ex_op)) && mem_op != OP_LOAD) ? 2'b01 :
              dep(wb_valid, wb_op, wb_rd, ex_rs1, use_rs1(ex_op)) ? 2'b10 : 2'b00;
    sel_b   = (dep(mem_valid, mem_op, mem_rd, ex_rs2, use_rs2(ex_op)) && mem_op != OP_LOAD) ? 2'b01 :
              dep(wb_valid, wb_op, wb_rd, ex_rs2, use_rs2(ex_op)) ? 2'b10 : 2'b00;
    fwd_a_o    = (!rst && FWD_EN && ex_valid) ? sel_a : 2'b00;
    fwd_b_o    = (!rst && FWD_EN && ex_valid) ? sel_b : 2'b00;
    stall_o    = !rst && (mem_stall_i || (!br_taken_i && hz));
    flush_o    = !rst && !mem_stall_i && br_taken_i;
    reg_w_en_o = !rst && wb_valid && wr_rd(wb_op) && (wb_rd != '0);
    mem_we_o   = !rst && mem_valid && mem_op == OP_ST;
  end
  // Stage advance with bubble insertion on flush/hazard; freeze holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      {ex_inst, mem_inst, wb_inst}    <= {NOP, NOP, NOP};
      {ex_valid, mem_valid, wb_valid} <= 3'b000;
      stall_cnt                       <= '0;
      flush_cnt                       <= '0;
    end else if (!mem_stall_i) begin
      ex_inst   <= bubble ? NOP : id_inst_i;
      ex_valid  <= !bubble && id_valid_i;
      mem_inst  <= ex_inst;
      mem_valid <= ex_valid;
      wb_inst   <= mem_inst;
      wb_valid  <= mem_valid;
      if (br_taken_i && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      if (!br_taken_i && hz && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  assign ex_inst_o   = ex_inst;
  assign mem_inst_o  = mem_inst;
  assign wb_inst_o   = wb_inst;
  assign ex_valid_o  = ex_valid;
  assign mem_valid_o = mem_valid;
  assign wb_valid_o  = wb_valid;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for both forwarding and interlock builds against a reference model
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                         LOAD = 7'b0000011, OPIMM = 7'b0010011, OP = 7'b0110011, BR = 7'b1100011,
                         ST = 7'b0100011, SYS = 7'b1110011;
  typedef struct packed {
    logic st, fl;
    logic [1:0] fa, fb;
    logic [31:0] ei, mi, wi;
    logic ev, mv, wv, we, sw;
    logic [CW-1:0] sc, fc;
  } obs_t;
  typedef struct {
    logic [31:0] i;
    bit v;
  } stg_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] id_inst = NOP;
  logic id_valid = 1'b0, br = 1'b0, ms = 1'b0;
  logic [1:0] st, fl, ev, mv, wv, we, sw;
  logic [1:0][1:0] fa, fb;
  logic [1:0][31:0] ei, mi, wi;
  logic [1:0][CW-1:0] sc, fc;
  obs_t q0[$], q1[$];
  stg_t pm[2][3];
  int scm[2], fcm[2];
  int n_chk = 0, n_fail = 0;
  bit last_stall = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.FWD_EN(1'b1), .REG_AW(5), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .id_inst_i(id_inst), .id_valid_i(id_valid), .br_taken_i(br), .mem_stall_i(ms),
    .stall_o(st[1]), .flush_o(fl[1]), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]),
    .ex_inst_o(ei[1]), .mem_inst_o(mi[1]), .wb_inst_o(wi[1]),
    .ex_valid_o(ev[1]), .mem_valid_o(mv[1]), .wb_valid_o(wv[1]),
    .reg_w_en_o(we[1]), .mem_we_o(sw[1]), .stall_cnt_o(sc[1]), .flush_cnt_o(fc[1]));
  pipe_hazard_ctrl #(.FWD_EN(1'b0), .REG_AW(5), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .id_inst_i(id_inst), .id_valid_i(id_valid), .br_taken_i(br), .mem_stall_i(ms),
    .stall_o(st[0]), .flush_o(fl[0]), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]),
    .ex_inst_o(ei[0]), .mem_inst_o(mi[0]), .wb_inst_o(wi[0]),
    .ex_valid_o(ev[0]), .mem_valid_o(mv[0]), .wb_valid_o(wv[0]),
    .reg_w_en_o(we[0]), .mem_we_o(sw[0]), .stall_cnt_o(sc[0]), .flush_cnt_o(fc[0]));
  function automatic bit writes(logic [31:0] i);
    return i[6:0] == LUI || i[6:0] == AUIPC || i[6:0] == JAL || i[6:0] == JALR ||
           i[6:0] == LOAD || i[6:0] == OPIMM || i[6:0] == OP;
  endfunction
  function automatic bit uses(logic [31:0] i, int k);
    if (k == 1) return i[6:0] == JALR || i[6:0] == BR || i[6:0] == LOAD || i[6:0] == ST || i[6:0] == OPIMM || i[6:0] == OP;
    return i[6:0] == BR || i[6:0] == ST || i[6:0] == OP;
  endfunction
  function automatic logic [4:0] src(logic [31:0] i, int k);
    return k == 1 ? i[19:15] : i[24:20];
  endfunction
  function automatic bit produces(stg_t s, logic [4:0] r);
    return s.v && writes(s.i) && s.i[11:7] != 5'd0 && s.i[11:7] == r;
  endfunction
  function automatic logic [31:0] mk(logic [6:0] op, int rd, int rs1, int rs2);
    logic [31:0] i;
    i = 32'd0;
    i[6:0] = op;
    i[11:7] = 5'(rd);
    i[19:15] = 5'(rs1);
    i[24:20] = 5'(rs2);
    return i;
  endfunction
  function automatic int sat(int c);
    return c == (1 << CW) - 1 ? c : c + 1;
  endfunction
  task automatic model(input int m, input bit fwd, output obs_t o);
    stg_t ex, me, wb, id, bub;
    bit hz;
    logic [1:0] sel[3];
    ex = pm[m][0]; me = pm[m][1]; wb = pm[m][2];
    id.i = id_inst; id.v = id_valid;
    bub.i = NOP; bub.v = 0;
    hz = 0;
    for (int k = 1; k <= 2; k++) begin
      if (id.v && uses(id.i, k)) begin
        if (produces(ex, src(id.i, k)) && (!fwd || ex.i[6:0] == LOAD)) hz = 1;
        if (!fwd && produces(me, src(id.i, k))) hz = 1;
      end
      sel[k] = 2'b00;
      if (!rst && fwd && ex.v && uses(ex.i, k)) begin
        if (produces(me, src(ex.i, k)) && me.i[6:0] != LOAD) sel[k] = 2'b01;
        else if (produces(wb, src(ex.i, k))) sel[k] = 2'b10;
      end
    end
    o.st = !rst && (ms || (!br && hz));
    o.fl = !rst && !ms && br;
    o.fa = sel[1];
    o.fb = sel[2];
    o.ei = ex.i; o.mi = me.i; o.wi = wb.i;
    o.ev = ex.v; o.mv = me.v; o.wv = wb.v;
    o.we = !rst && produces(wb, wb.i[11:7]);
    o.sw = !rst && me.v && me.i[6:0] == ST;
    o.sc = CW'(scm[m]);
    o.fc = CW'(fcm[m]);
    if (rst) begin
      for (int s = 0; s < 3; s++) pm[m][s] = bub;
      scm[m] = 0;
      fcm[m] = 0;
    end else if (!ms) begin
      pm[m][2] = me;
      pm[m][1] = ex;
      pm[m][0] = (br || hz) ? bub : id;
      if (br) fcm[m] = sat(fcm[m]);
      else if (hz) scm[m] = sat(scm[m]);
    end
  endtask
  task automatic step(input logic [31:0] i, input bit v, input bit b, input bit s, input bit r);
    obs_t o1, o0;
    id_inst = i; id_valid = v; br = b; ms = s; rst = r;
    model(1, 1, o1);
    model(0, 0, o0);
    q1.push_back(o1);
    q0.push_back(o0);
    last_stall = o1.st || o0.st;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] i);
    step(i, 1, 0, 0, 0);
    for (int n = 0; n < 6 && last_stall; n++) step(i, 1, 0, 0, 0);
  endtask
  task automatic check(input int m, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut_fwd%0d t=%0t: got %h expected %h", name, m, $time, act, exp);
    end
  endtask
  task automatic compare(input int m, input obs_t e);
    check(m, "stall", 32'(st[m]), 32'(e.st));
    check(m, "flush", 32'(fl[m]), 32'(e.fl));
    check(m, "fwd_a", 32'(fa[m]), 32'(e.fa));
    check(m, "fwd_b", 32'(fb[m]), 32'(e.fb));
    check(m, "ex_inst", ei[m], e.ei);
    check(m, "mem_inst", mi[m], e.mi);
    check(m, "wb_inst", wi[m], e.wi);
    check(m, "valids", 32'({ev[m], mv[m], wv[m]}), 32'({e.ev, e.mv, e.wv}));
    check(m, "reg_w_en", 32'(we[m]), 32'(e.we));
    check(m, "mem_we", 32'(sw[m]), 32'(e.sw));
    check(m, "stall_cnt", 32'(sc[m]), 32'(e.sc));
    check(m, "flush_cnt", 32'(fc[m]), 32'(e.fc));
  endtask
  // Monitor: pops the expected response for each presented cycle, away from the clock edge
  always @(negedge clk) begin
    if (q1.size() > 0) compare(1, q1.pop_front());
    if (q0.size() > 0) compare(0, q0.pop_front());
  end
  initial begin
    logic [6:0] ops[10];
    logic [31:0] ri;
    stg_t bub;
    ops = '{LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, BR, ST, SYS};
    bub.i = NOP; bub.v = 0;
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 3; s++) pm[m][s] = bub;
      scm[m] = 0;
      fcm[m] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    issue(mk(OP, 1, 2, 3));
    issue(mk(OP, 4, 1, 1));
    repeat (3) issue(NOP);
    issue(mk(OP, 1, 2, 3));
    issue(NOP);
    issue(mk(OP, 5, 1, 0) | 32'h4000_0000);
    issue(mk(OP, 0, 2, 3));
    issue(mk(OP, 6, 0, 0));
    repeat (3) issue(NOP);
    issue(mk(LOAD, 5, 2, 0));
    issue(mk(OP, 6, 5, 0));
    repeat (3) issue(NOP);
    issue(mk(BR, 0, 1, 2));
    step(mk(LOAD, 5, 2, 0), 1, 0, 0, 0);
    step(mk(OP, 6, 5, 0), 1, 1, 0, 0);
    step(NOP, 0, 0, 0, 0);
    issue(mk(ST, 0, 1, 2));
    issue(NOP);
    repeat (3) step(NOP, 1, 0, 1, 0);
    step(NOP, 1, 0, 0, 1);
    step(NOP, 1, 0, 0, 0);
    for (int n = 0; n < 40; n++) step(mk(LOAD, 1, 0, 0), 1, n % 3 == 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        ri = $urandom;
        ri[6:0] = ops[$urandom_range(0, 9)];
        ri[11:7] = 5'($urandom_range(0, 3));
        ri[19:15] = 5'($urandom_range(0, 3));
        ri[24:20] = 5'($urandom_range(0, 3));
        step(ri, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
      end else begin
        step(id_inst, id_valid, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
      end
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
